spi_slave_regs: RTL

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

---
 rtl/spi_slave_regs.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regs.sv
`timescale 1ns/1ps
// SPI mode-0 slave with a small 8-bit register file, fully clocked on sysclk.
// Frames are {cmd, addr, payload}, MSB first; sclk/cs/mosi are oversampled.
module spi_slave_regs #(
    parameter logic [7:0] CMD_WRITE = 8'h80,
    parameter logic [7:0] CMD_READ  = 8'h40,
    parameter int         REG_COUNT = 4
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic                   sclk,
    input  logic                   mosi,
    output logic                   miso,
    output logic [8*REG_COUNT-1:0] o_regs,
    output logic                   o_wr_strobe,
    output logic [7:0]             o_wr_addr,
    output logic                   o_frame_err
);

    localparam logic [8:0] REG_LIM = 9'(REG_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        PAYLOAD,
        DONE
    } state_t;

    state_t      state, state_nxt;

    logic        cs_p0, cs_p1, cs_p2;
    logic        sclk_p0, sclk_p1, sclk_p2;
    logic        mosi_p0, mosi_p1;
    logic        cs_fall, cs_rise, sclk_rise, sclk_fall, bit_vld;

    logic [4:0]  bit_cnt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [7:0]  cmd_byte, addr_byte;
    logic [7:0]  regs [REG_COUNT];
    logic [7:0]  rd_data, rd_shift;
    logic        rd_act, miso_bit;

    logic        sample, frame_start, latch_cmd, latch_addr;
    logic        load_rd, commit, frame_err_nxt;

    function automatic logic addr_ok(input logic [7:0] a);
        return ({1'b0, a} < REG_LIM);
    endfunction

    // Stage p0/p1: two-flop synchronizers; p2 holds the previous value for edge detect.
    // cs resets to "asserted" so a frame already in progress at reset release
    // never produces a falling edge and is ignored until cs cycles high.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign bit_vld   = sclk_rise & ~cs_p1;
    assign shift_nxt = {shift_reg[6:0], mosi_p1};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sample        = 1'b0;
        frame_start   = 1'b0;
        latch_cmd     = 1'b0;
        latch_addr    = 1'b0;
        load_rd       = 1'b0;
        commit        = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt   = CMD;
                    frame_start = 1'b1;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = 1'b1;
                end else if (bit_vld) begin
                    sample = 1'b1;
                    if (bit_cnt == 5'd7) begin
                        state_nxt = ADDR;
                        latch_cmd = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (cs_rise) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = 1'b1;
                end else if (bit_vld) begin
                    sample = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        state_nxt  = PAYLOAD;
                        latch_addr = 1'b1;
                        load_rd    = (cmd_byte == CMD_READ) && addr_ok(shift_nxt);
                    end
                end
            end
            PAYLOAD: begin
                if (cs_rise) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = 1'b1;
                end else if (bit_vld) begin
                    sample = 1'b1;
                    if (bit_cnt == 5'd23) begin
                        state_nxt = DONE;
                        if ((cmd_byte == CMD_WRITE) && addr_ok(addr_byte)) begin
                            commit = 1'b1;
                        end else if (!((cmd_byte == CMD_READ) && addr_ok(addr_byte))) begin
                            frame_err_nxt = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                // Overrun bits are simply not sampled here.
                if (cs_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            cmd_byte  <= '0;
            addr_byte <= '0;
        end else begin
            if (frame_start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (sample) begin
                bit_cnt   <= bit_cnt + 5'd1;
                shift_reg <= shift_nxt;
            end
            if (latch_cmd) begin
                cmd_byte <= shift_nxt;
            end
            if (latch_addr) begin
                addr_byte <= shift_nxt;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < REG_COUNT; k++) begin
            if (shift_nxt == 8'(k)) begin
                rd_data = regs[k];
            end
        end
    end

    // Read data leaves on synchronized sclk falling edges, so the master sees
    // bit 7 before its 17th rising edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_shift <= '0;
            rd_act   <= 1'b0;
            miso_bit <= 1'b0;
        end else if (load_rd) begin
            rd_shift <= rd_data;
            rd_act   <= 1'b1;
        end else if (state != PAYLOAD) begin
            rd_shift <= '0;
            rd_act   <= 1'b0;
            miso_bit <= 1'b0;
        end else if (rd_act && sclk_fall) begin
            miso_bit <= rd_shift[7];
            rd_shift <= {rd_shift[6:0], 1'b0};
        end
    end

    // Gate with the raw cs so miso drops immediately when the master deselects.
    assign miso = miso_bit & ~cs;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                regs[k] <= '0;
            end
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            for (int k = 0; k < REG_COUNT; k++) begin
                if (commit && (addr_byte == 8'(k))) begin
                    regs[k] <= shift_nxt;
                end
            end
            o_wr_strobe <= commit;
            if (commit) begin
                o_wr_addr <= addr_byte;
            end
            o_frame_err <= frame_err_nxt;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign o_regs[8*g +: 8] = regs[g];
    end

endmodule
